uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per bit (115200 baud at 100 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning receive buffer entries (power of two).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line (idle high).
REQ-006 SHALL have port rx_data, output, 8, the byte at the FIFO head.
REQ-007 SHALL have port rx_valid, output, 1, high when the FIFO is non-empty.
REQ-008 SHALL have port rx_ready, input, 1, consumer pop request.
REQ-009 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, the current occupancy.
REQ-010 SHALL have port frame_err, output, 1, a one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun, output, 1, a one-cycle pulse when a good byte is dropped.
REQ-012 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rxs.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, with a cycle counter cnt and a bit index idx[2:0].
REQ-015 IDLE: on rxs==0, go to START with cnt=0; otherwise stay.
REQ-016 START: when cnt==CLKS_PER_BIT/2-1 (433), sample rxs; if 0, go to DATA with cnt=0 and idx=0; if 1 (glitch), go to IDLE with no pulse.
REQ-017 DATA: when cnt==CLKS_PER_BIT-1, sample rxs into bit idx (LSB first) and reset cnt; after idx==7, go to STOP.
REQ-018 STOP: when cnt==CLKS_PER_BIT-1 (mid stop bit), return to IDLE in the same cycle so back-to-back frames are received.
REQ-019 STOP: if rxs==1 at that sample, push the byte; if 0, pulse frame_err for 1 cycle and push nothing.
REQ-020 Push SHALL be accepted when count<FIFO_DEPTH or a pop occurs in the same cycle; otherwise drop the byte and pulse overrun for 1 cycle.
REQ-021 A pop SHALL occur when rx_valid && rx_ready; rx_ready while empty SHALL be ignored.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged and keep FIFO order.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 rx_data/rx_valid SHALL reflect the head registered: a byte pushed into an empty FIFO appears the next cycle.
REQ-025 Latency: rx_valid SHALL rise CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 3 cycles (±1) after rx falls (2 synchronizer, 1 push).
REQ-026 frame_err and overrun SHALL never assert in the same cycle.

Reset
REQ-027 On rst: state=IDLE; cnt, idx, pointers and count=0; sync flops=1.
REQ-028 On rst: outputs rx_valid=0, rx_data=0, fifo_count=0, frame_err=0, overrun=0, busy=0.
REQ-029 Reset mid-frame SHALL discard the partial byte and FIFO contents.
REQ-030 After reset release, the first start bit SHALL be honoured only on a falling rxs seen from IDLE; a line held low SHALL still start a frame.

Structure
REQ-031 uart_pkg SHALL hold CLKS_PER_BIT default, the FSM state enum, and the data width (8).
REQ-032 The FIFO SHALL be a separate sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count).
REQ-033 Synchronizer and FSM SHALL live in uart_rx_fifo.

Verification
REQ-034 Frame 0xA5, stop=1, rx_ready=0 -> rx_valid rises ~8249 cycles after the start edge, rx_data=0xA5, fifo_count=1.
REQ-035 200-cycle low glitch on idle rx -> no push, no frame_err, busy returns to 0 by cycle ~436.
REQ-036 Frame 0x3C with stop=0 -> frame_err single pulse, fifo_count stays 0.
REQ-037 Nine back-to-back frames 0x01..0x09 with rx_ready=0 -> fifo_count=8, rx_data=0x01, one overrun pulse on the 9th; then popping yields 0x01..0x08 in order.
REQ-038 FIFO full with rx_ready=1 at the 9th stop sample -> push accepted, no overrun, count stays 8.
REQ-039 rst asserted at bit 4 of frame 0xFF, then frame 0x12 -> only 0x12 delivered, no error pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receiver with its receive FIFO.
package uart_pkg;

    // Default bit period: 115200 baud from a 100 MHz clock.
    localparam int CLKS_PER_BIT_DEF = 868;

    // Width of one received character.
    localparam int DATA_W = 8;

    // Receiver frame phases.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. DEPTH must be a power of two (>= 2)
// so the read/write pointers wrap naturally. A push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNTW'(DEPTH));
    assign count    = count_q;
    // The head is forced to zero when empty so the output is defined after reset.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, and a receive
// FIFO. frame_err and overrun are registered one-cycle pulses and cannot
// coincide because they come from opposite outcomes of the stop-bit sample.
// Handshake: a byte leaves the FIFO on any rising clk edge where
// rx_valid && rx_ready; rx_ready while rx_valid is low has no effect.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic              sync1_q, sync2_q;
    logic              rxs;
    rx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              push_req;
    logic              pop_fire;
    logic              fifo_full;
    logic              fifo_empty;

    assign rxs       = sync2_q;
    assign rx_valid  = !fifo_empty;
    assign pop_fire  = rx_valid && rx_ready;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

    // Two-stage synchronizer; idle-high reset value avoids a false start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM next-state: half-bit wait to centre on the start bit, then
    // whole-bit steps so every later sample lands mid-bit.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[DATA_W-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (rxs) push_req    = 1'b1;
                    else     frame_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        overrun_d = push_req && fifo_full && !pop_fire;
    end

    // FSM, shift register and error pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (shift_q),
        .pop       (pop_fire),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
